// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : wb_stage
//  Brief    : RV32I writeback stage - arbitrates ALU results and load data
//             into one registered register-file write port, formats loads
//             and tracks outstanding loads in a busy scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module wb_stage #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 5,
   parameter int NUM_REGS      = 32,
   parameter int MAX_ALU_STALL = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     alu_valid,
   output logic                     alu_ready,
   input  logic [ADDRESS_WIDTH-1:0] alu_dest,
   input  logic [DATA_WIDTH-1:0]    alu_data,
   input  logic                     load_valid,
   output logic                     load_ready,
   input  logic [ADDRESS_WIDTH-1:0] load_dest,
   input  logic [2:0]               load_funct3,
   input  logic [1:0]               load_addr_lo,
   input  logic [DATA_WIDTH-1:0]    load_rdata,
   input  logic                     issue_valid,
   input  logic [ADDRESS_WIDTH-1:0] issue_dest,
   output logic                     rg_wrt_en,
   output logic [ADDRESS_WIDTH-1:0] rg_wrt_dest,
   output logic [DATA_WIDTH-1:0]    rg_wrt_data,
   output logic [NUM_REGS-1:0]      busy,
   output logic                     load_err
);

   localparam int c_CNT_W = (MAX_ALU_STALL < 2) ? 1 : $clog2(MAX_ALU_STALL + 1);
   localparam logic [c_CNT_W-1:0] c_STALL_MAX = c_CNT_W'(MAX_ALU_STALL);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

   localparam logic [2:0] c_F3_LB  = 3'b000;
   localparam logic [2:0] c_F3_LH  = 3'b001;
   localparam logic [2:0] c_F3_LW  = 3'b010;
   localparam logic [2:0] c_F3_LBU = 3'b100;
   localparam logic [2:0] c_F3_LHU = 3'b101;

   logic [c_CNT_W-1:0]       r_stall_cnt;
   logic                     r_wrt_en;
   logic [ADDRESS_WIDTH-1:0] r_wrt_dest;
   logic [DATA_WIDTH-1:0]    r_wrt_data;
   logic [NUM_REGS-1:0]      r_busy;
   logic                     r_load_err;

   logic                     w_force;
   logic                     w_load_acc;
   logic                     w_alu_acc;
   logic [7:0]               w_byte;
   logic [15:0]              w_half;
   logic [DATA_WIDTH-1:0]    w_fmt;
   logic                     w_illegal;
   logic [NUM_REGS-1:0]      w_busy_nxt;

   // Loads normally win; the ALU is forced through after MAX_ALU_STALL losses.
   assign w_force    = (r_stall_cnt == c_STALL_MAX);
   assign load_ready = !w_force;
   assign alu_ready  = w_force | !load_valid;
   assign w_load_acc = load_valid & load_ready;
   assign w_alu_acc  = alu_valid & alu_ready;

   always_comb begin
      w_byte = load_rdata[7:0];
      case (load_addr_lo)
         2'd0: w_byte = load_rdata[7:0];
         2'd1: w_byte = load_rdata[15:8];
         2'd2: w_byte = load_rdata[23:16];
         2'd3: w_byte = load_rdata[31:24];
         default: w_byte = load_rdata[7:0];
      endcase
   end

   assign w_half = load_addr_lo[1] ? load_rdata[31:16] : load_rdata[15:0];

   always_comb begin
      w_fmt     = '0;
      w_illegal = 1'b0;
      case (load_funct3)
         c_F3_LB:  w_fmt = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
         c_F3_LBU: w_fmt = {{(DATA_WIDTH-8){1'b0}}, w_byte};
         c_F3_LH:  w_fmt = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
         c_F3_LHU: w_fmt = {{(DATA_WIDTH-16){1'b0}}, w_half};
         c_F3_LW:  w_fmt = load_rdata;
         default:  w_illegal = 1'b1;
      endcase
   end

   // Issue is applied after the clear so a same-cycle re-issue keeps the bit set.
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_load_acc)
         w_busy_nxt[load_dest] = 1'b0;
      if (issue_valid && (issue_dest != '0))
         w_busy_nxt[issue_dest] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
         r_wrt_en    <= 1'b0;
         r_wrt_dest  <= '0;
         r_wrt_data  <= '0;
         r_busy      <= '0;
         r_load_err  <= 1'b0;
      end else begin
         if (alu_valid && !alu_ready)
            r_stall_cnt <= (r_stall_cnt == c_STALL_MAX) ? r_stall_cnt
                                                        : r_stall_cnt + c_CNT_ONE;
         else
            r_stall_cnt <= '0;

         r_busy     <= w_busy_nxt;
         r_load_err <= w_load_acc & w_illegal;

         if (w_load_acc) begin
            r_wrt_en   <= !w_illegal && (load_dest != '0);
            r_wrt_dest <= load_dest;
            r_wrt_data <= w_fmt;
         end else if (w_alu_acc) begin
            r_wrt_en   <= (alu_dest != '0);
            r_wrt_dest <= alu_dest;
            r_wrt_data <= alu_data;
         end else begin
            r_wrt_en   <= 1'b0;
         end
      end
   end

   assign rg_wrt_en   = r_wrt_en;
   assign rg_wrt_dest = r_wrt_dest;
   assign rg_wrt_data = r_wrt_data;
   assign busy        = r_busy;
   assign load_err    = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_stage
//  Brief    : Directed and randomized bench for wb_stage against a
//             behavioural model of arbitration, load formatting and scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_stage;

   logic        clk;
   logic        rst_n;
   logic        alu_valid;
   logic        alu_ready;
   logic [4:0]  alu_dest;
   logic [31:0] alu_data;
   logic        load_valid;
   logic        load_ready;
   logic [4:0]  load_dest;
   logic [2:0]  load_funct3;
   logic [1:0]  load_addr_lo;
   logic [31:0] load_rdata;
   logic        issue_valid;
   logic [4:0]  issue_dest;
   logic        rg_wrt_en;
   logic [4:0]  rg_wrt_dest;
   logic [31:0] rg_wrt_data;
   logic [31:0] busy;
   logic        load_err;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state
   int          m_losses;
   logic [31:0] m_busy;
   logic        m_en;
   logic        m_err;
   logic [4:0]  m_dest;
   logic [31:0] m_data;

   wb_stage #(
      .DATA_WIDTH(32), .ADDRESS_WIDTH(5), .NUM_REGS(32), .MAX_ALU_STALL(2)
   ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_data(alu_data),
      .load_valid(load_valid), .load_ready(load_ready), .load_dest(load_dest),
      .load_funct3(load_funct3), .load_addr_lo(load_addr_lo), .load_rdata(load_rdata),
      .issue_valid(issue_valid), .issue_dest(issue_dest),
      .rg_wrt_en(rg_wrt_en), .rg_wrt_dest(rg_wrt_dest), .rg_wrt_data(rg_wrt_data),
      .busy(busy), .load_err(load_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] w, output bit legal);
      int unsigned b, h;
      b = (w >> (8 * int'(off))) & 32'hFF;
      h = (w >> (off[1] ? 16 : 0)) & 32'hFFFF;
      legal = 1'b1;
      case (f3)
         3'd0: return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
         3'd4: return b;
         3'd1: return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
         3'd5: return h;
         3'd2: return w;
         default: begin
            legal = 1'b0;
            return 32'h0;
         end
      endcase
   endfunction

   task automatic model_reset();
      m_losses = 0;
      m_busy   = '0;
      m_en     = 1'b0;
      m_err    = 1'b0;
      m_dest   = '0;
      m_data   = '0;
   endtask

   task automatic idle();
      alu_valid   = 1'b0;
      load_valid  = 1'b0;
      issue_valid = 1'b0;
   endtask

   // Called right after inputs are driven at a negedge; ends at the next negedge.
   task automatic step();
      bit          forced, exp_lr, exp_ar, take_load, take_alu, legal;
      logic [31:0] fd;
      forced = (m_losses == 2);
      exp_lr = !forced;
      exp_ar = forced || !load_valid;
      #1;
      chk("load_ready", {31'b0, load_ready}, {31'b0, exp_lr});
      chk("alu_ready",  {31'b0, alu_ready},  {31'b0, exp_ar});

      // Priority view: a starved ALU goes first, otherwise loads beat the ALU.
      take_load = 1'b0;
      take_alu  = 1'b0;
      if (forced)          take_alu  = alu_valid;
      else if (load_valid) take_load = 1'b1;
      else                 take_alu  = alu_valid;

      m_err = 1'b0;
      if (take_load) begin
         fd     = ref_load(load_funct3, load_addr_lo, load_rdata, legal);
         m_en   = legal && (load_dest != 0);
         m_err  = !legal;
         m_dest = load_dest;
         m_data = fd;
         m_busy[load_dest] = 1'b0;
      end else if (take_alu) begin
         m_en   = (alu_dest != 0);
         m_dest = alu_dest;
         m_data = alu_data;
      end else begin
         m_en = 1'b0;
      end
      if (issue_valid && issue_dest != 0)
         m_busy[issue_dest] = 1'b1;
      if (alu_valid && !take_alu) m_losses = (m_losses < 2) ? m_losses + 1 : 2;
      else                        m_losses = 0;

      @(posedge clk);
      @(negedge clk);
      chk("wrt_en",   {31'b0, rg_wrt_en}, {31'b0, m_en});
      chk("wrt_dest", {27'b0, rg_wrt_dest}, {27'b0, m_dest});
      chk("wrt_data", rg_wrt_data, m_data);
      chk("busy",     busy, m_busy);
      chk("load_err", {31'b0, load_err}, {31'b0, m_err});
   endtask

   task automatic drive_load(input logic [4:0] d, input logic [2:0] f3,
                             input logic [1:0] off, input logic [31:0] w);
      load_valid   = 1'b1;
      load_dest    = d;
      load_funct3  = f3;
      load_addr_lo = off;
      load_rdata   = w;
   endtask

   logic [2:0] f3_tab [10] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd0, 3'd4, 3'd3, 3'd7};

   initial begin
      rst_n = 1'b0;
      idle();
      alu_dest = '0; alu_data = '0;
      load_dest = '0; load_funct3 = '0; load_addr_lo = '0; load_rdata = '0;
      issue_dest = '0;
      model_reset();

      repeat (2) @(negedge clk);
      chk("rst_en",   {31'b0, rg_wrt_en}, 32'h0);
      chk("rst_busy", busy, 32'h0);
      chk("rst_data", rg_wrt_data, 32'h0);
      chk("rst_err",  {31'b0, load_err}, 32'h0);
      rst_n = 1'b1;

      // ALU only
      idle(); alu_valid = 1'b1; alu_dest = 5'd3; alu_data = 32'h1234_5678;
      step();
      chk("alu_en",   {31'b0, rg_wrt_en}, 32'h1);
      chk("alu_dest", {27'b0, rg_wrt_dest}, 32'd3);
      chk("alu_data", rg_wrt_data, 32'h1234_5678);

      // Load formatting
      idle(); drive_load(5'd4, 3'b000, 2'd1, 32'h80FF_7F01); step();
      chk("lb_off1", rg_wrt_data, 32'h0000_007F);
      idle(); drive_load(5'd4, 3'b000, 2'd3, 32'h80FF_7F01); step();
      chk("lb_off3", rg_wrt_data, 32'hFFFF_FF80);
      idle(); drive_load(5'd4, 3'b101, 2'd2, 32'h80FF_7F01); step();
      chk("lhu_off2", rg_wrt_data, 32'h0000_80FF);
      idle(); drive_load(5'd4, 3'b001, 2'd2, 32'h80FF_7F01); step();
      chk("lh_off2", rg_wrt_data, 32'hFFFF_80FF);
      idle(); drive_load(5'd4, 3'b011, 2'd0, 32'h80FF_7F01); step();
      chk("bad_err", {31'b0, load_err}, 32'h1);
      chk("bad_en",  {31'b0, rg_wrt_en}, 32'h0);
      idle(); step();
      chk("err_pulse", {31'b0, load_err}, 32'h0);

      // Fairness: both sources held valid
      idle(); alu_valid = 1'b1; alu_dest = 5'd10; alu_data = 32'hAAAA_0001;
      drive_load(5'd11, 3'b010, 2'd0, 32'h5555_0002);
      step(); chk("fair_c1", rg_wrt_data, 32'h5555_0002);
      step(); chk("fair_c2", rg_wrt_data, 32'h5555_0002);
      #1 chk("fair_lr_low", {31'b0, load_ready}, 32'h0);
      @(negedge clk);
      // A full cycle was consumed above: realign by re-entering at this negedge.
      // The sampled cycle is re-evaluated by step() with unchanged inputs.
      model_reset();
      rst_n = 1'b0; #1 rst_n = 1'b1;
      idle(); step();
      alu_valid = 1'b1; drive_load(5'd11, 3'b010, 2'd0, 32'h5555_0002);
      step(); step(); step();
      chk("fair_c3_alu", rg_wrt_data, 32'hAAAA_0001);
      step(); chk("fair_c4_load", rg_wrt_data, 32'h5555_0002);

      // Scoreboard
      idle(); issue_valid = 1'b1; issue_dest = 5'd7; step();
      chk("sb_set7", {31'b0, busy[7]}, 32'h1);
      idle(); issue_valid = 1'b1; issue_dest = 5'd7;
      drive_load(5'd7, 3'b010, 2'd0, 32'hCAFE_F00D); step();
      chk("sb_setwins", {31'b0, busy[7]}, 32'h1);
      idle(); issue_valid = 1'b1; issue_dest = 5'd0; step();
      chk("sb_x0", {31'b0, busy[0]}, 32'h0);
      idle(); drive_load(5'd0, 3'b010, 2'd0, 32'h1111_2222); step();
      chk("x0_noen", {31'b0, rg_wrt_en}, 32'h0);

      // Reset in the middle of a write
      idle(); alu_valid = 1'b1; alu_dest = 5'd5; alu_data = 32'hA5;
      issue_valid = 1'b1; issue_dest = 5'd9; step();
      chk("pre_rst_en", {31'b0, rg_wrt_en}, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("mid_rst_en",   {31'b0, rg_wrt_en}, 32'h0);
      chk("mid_rst_busy", busy, 32'h0);
      chk("mid_rst_dest", {27'b0, rg_wrt_dest}, 32'h0);
      @(negedge clk);
      idle();
      chk("in_rst_en", {31'b0, rg_wrt_en}, 32'h0);
      rst_n = 1'b1;
      step();
      chk("post_rst_en", {31'b0, rg_wrt_en}, 32'h0);

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         alu_valid    = ($urandom_range(0, 9) < 6);
         alu_dest     = 5'($urandom_range(0, 31));
         alu_data     = $urandom;
         load_valid   = ($urandom_range(0, 9) < 6);
         load_dest    = 5'($urandom_range(0, 31));
         load_funct3  = f3_tab[$urandom_range(0, 9)];
         load_addr_lo = 2'($urandom_range(0, 3));
         load_rdata   = $urandom;
         issue_valid  = ($urandom_range(0, 9) < 4);
         issue_dest   = 5'($urandom_range(0, 31));
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
